// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - Wishbone shared encodings and RMW state type
// Ports: none (package). Granularity and mode encodings match wb_slave_adapter.
package wb_pkg;

  // Address unit of sl_adr_i
  localparam int c_wb_byte = 0;
  localparam int c_wb_word = 1;

  // Bus mode
  localparam int c_wb_classic   = 0;
  localparam int c_wb_pipelined = 1;

  // Stall FSM for partial-select writes
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RMW  = 1'b1
  } rmw_state_t;

endpackage

// File: rtl/generic_spram.sv
// rtl/generic_spram.sv - single-port synchronous RAM, read-during-write returns old data
// Ports:
//   clk_i    in   clock
//   addr_i   in   word address
//   we_i     in   write enable (whole word)
//   wdata_i  in   write data
//   rdata_o  out  registered read data of addr_i at the previous edge
module generic_spram #(
  parameter int g_width = 32,
  parameter int g_depth = 8192,
  parameter int g_aw    = 13
) (
  input  logic               clk_i,
  input  logic [g_aw-1:0]    addr_i,
  input  logic               we_i,
  input  logic [g_width-1:0] wdata_i,
  output logic [g_width-1:0] rdata_o
);

  logic [g_width-1:0] mem_q [g_depth];
  logic [g_width-1:0] rdata_q;
  logic [g_width-1:0] rdata_d;

  // Read sees the array before this edge's write lands: old data on collision.
  always_comb begin
    rdata_d = mem_q[addr_i];
  end

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_q <= rdata_d;
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/wb_pipe_ram_slave.sv
// rtl/wb_pipe_ram_slave.sv - pipelined Wishbone RAM slave with RMW for partial writes
// Ports:
//   clk_i, rst_i          clock, async active-high reset
//   sl_adr_i/dat_i/sel_i  request address, write data, byte selects
//   sl_we_i/cyc_i/stb_i   request qualifiers
//   sl_dat_o              read data, 0 unless acking a read
//   sl_ack_o/sl_err_o     in-order terminations, fixed latency
//   sl_stall_o            high for one cycle during a partial-write RMW
module wb_pipe_ram_slave
  import wb_pkg::*;
#(
  parameter int g_data_width   = 32,
  parameter int g_mem_words    = 8192,
  parameter int g_granularity  = c_wb_byte,
  parameter int g_read_latency = 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [31:0]               sl_adr_i,
  input  logic [g_data_width-1:0]   sl_dat_i,
  input  logic [g_data_width/8-1:0] sl_sel_i,
  input  logic                      sl_we_i,
  input  logic                      sl_cyc_i,
  input  logic                      sl_stb_i,
  output logic [g_data_width-1:0]   sl_dat_o,
  output logic                      sl_ack_o,
  output logic                      sl_err_o,
  output logic                      sl_stall_o
);

  localparam int c_sel_w = g_data_width / 8;
  localparam int c_shift = (c_sel_w > 1) ? $clog2(c_sel_w) : 0;
  localparam int c_aw    = (g_mem_words > 1) ? $clog2(g_mem_words) : 1;

  rmw_state_t state_q, state_d;
  logic stall_q, stall_d;

  logic [c_aw-1:0]         rmw_idx_q, rmw_idx_d;
  logic [g_data_width-1:0] rmw_dat_q, rmw_dat_d;
  logic [c_sel_w-1:0]      rmw_sel_q, rmw_sel_d;

  // Response stage 0: valid, error, carries-read-data
  logic v0_q, v0_d;
  logic e0_q, e0_d;
  logic r0_q, r0_d;

  logic [31:0]             word_idx;
  logic                    in_range;
  logic                    accept;
  logic                    sel_full;
  logic                    sel_none;
  logic                    is_partial;
  logic [c_aw-1:0]         ram_addr;
  logic                    ram_we;
  logic [g_data_width-1:0] ram_wdata;
  logic [g_data_width-1:0] ram_rdata;
  logic [g_data_width-1:0] merged;

  always_comb begin
    if (g_granularity == c_wb_byte) begin
      word_idx = sl_adr_i >> c_shift;
    end else begin
      word_idx = sl_adr_i;
    end
  end

  assign in_range   = (word_idx < 32'(g_mem_words));
  assign accept     = sl_cyc_i & sl_stb_i & ~stall_q;
  assign sel_full   = &sl_sel_i;
  assign sel_none   = ~|sl_sel_i;
  assign is_partial = sl_we_i & in_range & ~sel_full & ~sel_none;

  // Selected bytes from the latched write data, the rest from the word read at acceptance.
  always_comb begin
    merged = ram_rdata;
    for (int b = 0; b < c_sel_w; b++) begin
      if (rmw_sel_q[b]) begin
        merged[8*b +: 8] = rmw_dat_q[8*b +: 8];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rmw_idx_d = rmw_idx_q;
    rmw_dat_d = rmw_dat_q;
    rmw_sel_d = rmw_sel_q;
    ram_addr  = word_idx[c_aw-1:0];
    ram_we    = 1'b0;
    ram_wdata = sl_dat_i;
    v0_d      = 1'b0;
    e0_d      = 1'b0;
    r0_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (is_partial) begin
            // RAM read of the target word is issued this edge via ram_addr.
            state_d   = ST_RMW;
            rmw_idx_d = word_idx[c_aw-1:0];
            rmw_dat_d = sl_dat_i;
            rmw_sel_d = sl_sel_i;
          end else begin
            v0_d   = 1'b1;
            e0_d   = ~in_range;
            r0_d   = ~sl_we_i & in_range;
            ram_we = sl_we_i & in_range & sel_full;
          end
        end
      end
      ST_RMW: begin
        // Write completes even if the cycle was abandoned; only the ack is dropped.
        ram_addr  = rmw_idx_q;
        ram_we    = 1'b1;
        ram_wdata = merged;
        v0_d      = 1'b1;
        state_d   = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Dropping cyc kills any response entering the pipe.
    v0_d    = v0_d & sl_cyc_i;
    stall_d = (state_d == ST_RMW);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      stall_q   <= 1'b0;
      rmw_idx_q <= '0;
      rmw_dat_q <= '0;
      rmw_sel_q <= '0;
      v0_q      <= 1'b0;
      e0_q      <= 1'b0;
      r0_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      stall_q   <= stall_d;
      rmw_idx_q <= rmw_idx_d;
      rmw_dat_q <= rmw_dat_d;
      rmw_sel_q <= rmw_sel_d;
      v0_q      <= v0_d;
      e0_q      <= e0_d;
      r0_q      <= r0_d;
    end
  end

  generic_spram #(
    .g_width(g_data_width),
    .g_depth(g_mem_words),
    .g_aw   (c_aw)
  ) u_ram (
    .clk_i  (clk_i),
    .addr_i (ram_addr),
    .we_i   (ram_we),
    .wdata_i(ram_wdata),
    .rdata_o(ram_rdata)
  );

  generate
    if (g_read_latency == 2) begin : g_lat2
      logic                    v1_q, v1_d;
      logic                    e1_q, e1_d;
      logic [g_data_width-1:0] d1_q, d1_d;

      always_comb begin
        v1_d = v0_q & sl_cyc_i;
        e1_d = e0_q;
        d1_d = (v0_q & r0_q & sl_cyc_i) ? ram_rdata : '0;
      end

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          v1_q <= 1'b0;
          e1_q <= 1'b0;
          d1_q <= '0;
        end else begin
          v1_q <= v1_d;
          e1_q <= e1_d;
          d1_q <= d1_d;
        end
      end

      assign sl_ack_o = v1_q & ~e1_q;
      assign sl_err_o = v1_q & e1_q;
      assign sl_dat_o = d1_q;
    end else begin : g_lat1
      // RAM output register serves as the response data register.
      assign sl_ack_o = v0_q & ~e0_q;
      assign sl_err_o = v0_q & e0_q;
      assign sl_dat_o = (v0_q & r0_q) ? ram_rdata : '0;
    end
  endgenerate

  assign sl_stall_o = stall_q;

endmodule

// File: tb/tb_wb_pipe_ram_slave.sv
// tb/tb_wb_pipe_ram_slave.sv - directed bench for wb_pipe_ram_slave at latency 1 and 2
module tb_wb_pipe_ram_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] adr = '0;
  logic [31:0] dat = '0;
  logic [3:0]  sel = '0;
  logic        we  = 1'b0;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;

  logic [31:0] dat1, dat2;
  logic        ack1, err1, stall1;
  logic        ack2, err2, stall2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  wb_pipe_ram_slave #(.g_read_latency(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .sl_adr_i(adr), .sl_dat_i(dat), .sl_sel_i(sel),
    .sl_we_i(we), .sl_cyc_i(cyc), .sl_stb_i(stb), .sl_dat_o(dat1),
    .sl_ack_o(ack1), .sl_err_o(err1), .sl_stall_o(stall1)
  );

  wb_pipe_ram_slave #(.g_read_latency(2)) dut2 (
    .clk_i(clk), .rst_i(rst), .sl_adr_i(adr), .sl_dat_i(dat), .sl_sel_i(sel),
    .sl_we_i(we), .sl_cyc_i(cyc), .sl_stb_i(stb), .sl_dat_o(dat2),
    .sl_ack_o(ack2), .sl_err_o(err2), .sl_stall_o(stall2)
  );

  function automatic logic [63:0] rsp(input logic a, input logic e, input logic st,
                                      input logic [31:0] d);
    return {29'd0, a, e, st, d};
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  // One request, no stall expected; checks both latencies against the given response.
  task automatic single(input string tag, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic w,
                        input logic e_ack, input logic e_err, input logic [31:0] e_dat);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = d; sel = s;
    @(posedge clk);
    @(negedge clk);
    stb = 1'b0; we = 1'b0;
    check_eq({tag, ".l1"}, rsp(ack1, err1, stall1, dat1), rsp(e_ack, e_err, 1'b0, e_dat));
    check_eq({tag, ".l2early"}, rsp(ack2, err2, stall2, dat2), rsp(1'b0, 1'b0, 1'b0, 32'd0));
    @(negedge clk);
    check_eq({tag, ".l1idle"}, rsp(ack1, err1, stall1, dat1), rsp(1'b0, 1'b0, 1'b0, 32'd0));
    check_eq({tag, ".l2"}, rsp(ack2, err2, stall2, dat2), rsp(e_ack, e_err, 1'b0, e_dat));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Idle bus after reset
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("reset.l1", rsp(ack1, err1, stall1, dat1), 64'd0);
      check_eq("reset.l2", rsp(ack2, err2, stall2, dat2), 64'd0);
    end

    // Full write then read, byte addressing: 0x40 -> index 0x10
    single("wr40", 32'h40, 32'hDEADBEEF, 4'hF, 1'b1, 1'b1, 1'b0, 32'd0);
    check_eq("mem10", {32'd0, dut1.u_ram.mem_q[16]}, {32'd0, 32'hDEADBEEF});
    single("rd40", 32'h40, 32'd0, 4'h0, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF);

    // Zero-select write: acked, no change
    single("wr0sel", 32'h40, 32'h12345678, 4'h0, 1'b1, 1'b1, 1'b0, 32'd0);
    single("rd40b", 32'h40, 32'd0, 4'h0, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF);

    // stb without cyc is ignored
    @(negedge clk);
    cyc = 1'b0; stb = 1'b1; we = 1'b1; adr = 32'h40; dat = 32'h0; sel = 4'hF;
    @(negedge clk);
    stb = 1'b0; we = 1'b0;
    check_eq("nocyc.l1", rsp(ack1, err1, stall1, dat1), 64'd0);
    @(negedge clk);
    check_eq("nocyc.l2", rsp(ack2, err2, stall2, dat2), 64'd0);
    single("rd40c", 32'h40, 32'd0, 4'h0, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF);

    // Partial write: 0x11223344 with 0xAABBCCDD, sel 0x5 -> 0x11BB33DD
    single("wr80", 32'h80, 32'h11223344, 4'hF, 1'b1, 1'b1, 1'b0, 32'd0);
    @(negedge clk);
    stb = 1'b1; we = 1'b1; adr = 32'h80; dat = 32'hAABBCCDD; sel = 4'h5;
    @(posedge clk);
    @(negedge clk);
    stb = 1'b0; we = 1'b0;
    check_eq("rmw.stall", rsp(ack1, err1, stall1, dat1), rsp(1'b0, 1'b0, 1'b1, 32'd0));
    check_eq("rmw.stall2", {63'd0, stall2}, 64'd1);
    @(negedge clk);
    check_eq("rmw.ack1", rsp(ack1, err1, stall1, dat1), rsp(1'b1, 1'b0, 1'b0, 32'd0));
    check_eq("rmw.l2early", rsp(ack2, err2, stall2, dat2), 64'd0);
    @(negedge clk);
    check_eq("rmw.l1idle", rsp(ack1, err1, stall1, dat1), 64'd0);
    check_eq("rmw.ack2", rsp(ack2, err2, stall2, dat2), rsp(1'b1, 1'b0, 1'b0, 32'd0));
    single("rd80", 32'h80, 32'd0, 4'h0, 1'b0, 1'b1, 1'b0, 32'h11BB33DD);

    // Preload indices 0..3 with 0..3, then four back-to-back reads
    for (int i = 0; i < 4; i++) begin
      single("pre", 32'(4 * i), 32'(i), 4'hF, 1'b1, 1'b1, 1'b0, 32'd0);
    end
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h0; sel = 4'hF;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk);
      @(negedge clk);
      check_eq("b2b.l1", rsp(ack1, err1, stall1, dat1),
               (i <= 3) ? rsp(1'b1, 1'b0, 1'b0, 32'(i)) : 64'd0);
      check_eq("b2b.l2", rsp(ack2, err2, stall2, dat2),
               (i >= 1 && i <= 4) ? rsp(1'b1, 1'b0, 1'b0, 32'(i - 1)) : 64'd0);
      if (i < 3) adr = 32'(4 * (i + 1));
      else stb = 1'b0;
    end

    // Out of range: index 8192 errs, write must not alias onto index 0
    single("oor.rd", 32'h8000, 32'd0, 4'hF, 1'b0, 1'b0, 1'b1, 32'd0);
    single("oor.wr", 32'h8000, 32'hBAD0BAD0, 4'hF, 1'b1, 1'b0, 1'b1, 32'd0);
    single("rd0", 32'h0, 32'd0, 4'hF, 1'b0, 1'b1, 1'b0, 32'd0);
    single("rd4", 32'h4, 32'd0, 4'hF, 1'b0, 1'b1, 1'b0, 32'd1);

    // Abandon cycle during RMW: 0x55667788 + 0x99AABBCC sel 0xA -> 0x9966BB88, no ack
    single("wrC0", 32'hC0, 32'h55667788, 4'hF, 1'b1, 1'b1, 1'b0, 32'd0);
    @(negedge clk);
    stb = 1'b1; we = 1'b1; adr = 32'hC0; dat = 32'h99AABBCC; sel = 4'hA;
    @(posedge clk);
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    check_eq("drop.stall", {63'd0, stall1}, 64'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("drop.l1", rsp(ack1, err1, stall1, dat1), 64'd0);
      check_eq("drop.l2", rsp(ack2, err2, stall2, dat2), 64'd0);
    end
    single("rdC0", 32'hC0, 32'd0, 4'hF, 1'b0, 1'b1, 1'b0, 32'h9966BB88);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
